// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: IF/ID payload, next-PC
// select encoding and the saturating increment used by the perf counters.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

  typedef enum logic [2:0] {
    SEL_FLUSH,
    SEL_JUMP,
    SEL_PEND,
    SEL_PRED,
    SEL_HOLD,
    SEL_SEQ
  } next_pc_sel_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush beats stall; a flush only invalidates the
// slot (instr -> NOP, valid -> 0) and leaves the PC fields untouched.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_stall,
  input  logic  i_flush,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q.pc       <= '0;
      r_q.pc_plus4 <= '0;
      r_q.instr    <= NOP_INSTR;
      r_q.valid    <= 1'b0;
    end else if (i_flush) begin
      r_q.instr <= NOP_INSTR;
      r_q.valid <= 1'b0;
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch-stage PC generator with pending predicted-redirect buffer and IF/ID
// register. Optional perf counters are enabled with the FETCH_PERF_EN macro.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = XLEN,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] InstrF,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic [DATA_WIDTH-1:0] PCBPU,
  input  logic                  PCBPUSrc,
  input  logic                  flushBranch,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic [DATA_WIDTH-1:0] InstrD,
`ifdef FETCH_PERF_EN
  output logic [31:0]           PerfFetched,
  output logic [31:0]           PerfSquashed,
  output logic [31:0]           PerfRedirects,
`endif
  output logic                  ValidD
);

  logic [DATA_WIDTH-1:0] r_pcf;
  logic                  r_pend_valid;
  logic [DATA_WIDTH-1:0] r_pend_target;

  next_pc_sel_t          w_sel;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic                  w_shadow_kill;
  logic                  w_flush_d;
  ifid_t                 w_ifid_d;
  ifid_t                 w_ifid_q;

  assign w_pc_plus4 = r_pcf + DATA_WIDTH'(4);

  always_comb begin
    w_sel = SEL_SEQ;
    if (flushBranch)                   w_sel = SEL_FLUSH;
    else if (PCSrcE)                   w_sel = SEL_JUMP;
    else if (r_pend_valid && !StallF)  w_sel = SEL_PEND;
    else if (PCBPUSrc && !StallF)      w_sel = SEL_PRED;
    else if (StallF)                   w_sel = SEL_HOLD;
  end

  always_comb begin
    w_pc_next = w_pc_plus4;
    case (w_sel)
      SEL_FLUSH: w_pc_next = PCBPU;
      SEL_JUMP:  w_pc_next = PCTargetE;
      SEL_PEND:  w_pc_next = r_pend_target;
      SEL_PRED:  w_pc_next = PCBPU;
      SEL_HOLD:  w_pc_next = r_pcf;
      default:   w_pc_next = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pcf <= RESET_PC;
    else     r_pcf <= w_pc_next;
  end

  // A prediction that arrives while fetch is stalled is parked until the
  // stall lifts; a later prediction during the same stall replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else if (flushBranch || PCSrcE) begin
      r_pend_valid <= 1'b0;
    end else if (PCBPUSrc && StallF) begin
      r_pend_valid  <= 1'b1;
      r_pend_target <= PCBPU;
    end else if (w_sel == SEL_PEND) begin
      r_pend_valid <= 1'b0;
    end
  end

  // The word at PCF while a predicted redirect is applied is wrong-path.
  assign w_shadow_kill = (w_sel == SEL_PEND) || (w_sel == SEL_PRED);
  assign w_flush_d     = flushBranch || PCSrcE || FlushD;

  always_comb begin
    w_ifid_d.pc       = r_pcf;
    w_ifid_d.pc_plus4 = w_pc_plus4;
    w_ifid_d.instr    = w_shadow_kill ? NOP_INSTR : InstrF;
    w_ifid_d.valid    = !w_shadow_kill;
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_stall (StallD),
    .i_flush (w_flush_d),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign PCF      = r_pcf;
  assign PCD      = w_ifid_q.pc;
  assign PCPlus4D = w_ifid_q.pc_plus4;
  assign InstrD   = w_ifid_q.instr;
  assign ValidD   = w_ifid_q.valid;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_squashed;
  logic [31:0] r_perf_redirects;
  logic        w_capture;

  assign w_capture = !w_flush_d && !StallD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched   <= '0;
      r_perf_squashed  <= '0;
      r_perf_redirects <= '0;
    end else begin
      if (w_capture && !w_shadow_kill)
        r_perf_fetched <= sat_inc(r_perf_fetched);
      if (w_flush_d || (w_capture && w_shadow_kill))
        r_perf_squashed <= sat_inc(r_perf_squashed);
      if ((w_sel == SEL_FLUSH) || (w_sel == SEL_JUMP))
        r_perf_redirects <= sat_inc(r_perf_redirects);
    end
  end

  assign PerfFetched   = r_perf_fetched;
  assign PerfSquashed  = r_perf_squashed;
  assign PerfRedirects = r_perf_redirects;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Fetch-stage PC generator and IF/ID pipeline register, directly downstream of the branch prediction unit: it consumes PCBPU/PCBPUSrc/flushBranch and feeds PCF back to instruction memory and the BPU. It selects next PC by a fixed priority, holds a pending predicted redirect across fetch stalls, and squashes the shadow instruction fetched before a registered prediction takes effect. It also squashes the instruction fetched after an execute-stage jump redirect.

Parameters:
DATA_WIDTH, 32, width of PC and instruction
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
InstrF  in  DATA_WIDTH  instruction memory read data for PCF (combinational)
StallF  in  1  hazard unit: hold PC
StallD  in  1  hazard unit: hold IF/ID register
FlushD  in  1  hazard unit: invalidate IF/ID
PCBPU  in  DATA_WIDTH  BPU target (prediction or correction)
PCBPUSrc  in  1  BPU predicted-taken pulse (registered, 1 cycle after fetch)
flushBranch  in  1  BPU mispredict: redirect to PCBPU, flush
PCSrcE  in  1  execute-stage jump redirect (jal/jalr)
PCTargetE  in  DATA_WIDTH  jump target
PCF  out  DATA_WIDTH  current fetch PC
PCD  out  DATA_WIDTH  PC of instruction in decode
PCPlus4D  out  DATA_WIDTH  PCD + 4
InstrD  out  DATA_WIDTH  decode instruction (32'h0000_0013 NOP when invalid)
ValidD  out  1  decode slot holds a real instruction

Behaviour:
- Reset (async): PCF=RESET_PC, PCD=0, PCPlus4D=0, InstrD=NOP, ValidD=0, pend_valid=0, pend_target=0, shadow_kill=0.
- Next-PC priority, evaluated each rising edge:
  1. flushBranch -> PCF<=PCBPU.
  2. PCSrcE -> PCF<=PCTargetE.
  3. pend_valid and !StallF -> PCF<=pend_target.
  4. PCBPUSrc and !StallF -> PCF<=PCBPU.
  5. StallF -> hold.
  6. Otherwise PCF<=PCF+4, modulo 2^DATA_WIDTH.
- Pending redirect handling:
  - PCBPUSrc while StallF: pend_valid<=1, pend_target<=PCBPU.
  - pend_valid clears when consumed (case 3), or on flushBranch/PCSrcE.
  - A new PCBPUSrc while pend_valid is already set overwrites pend_target.
- Shadow squash: the instruction being fetched in the cycle a predicted redirect (case 3 or 4) is applied is wrong-path. It enters IF/ID with ValidD=0 and InstrD=NOP.
- IF/ID register update:
  - flushBranch, PCSrcE, or FlushD: ValidD<=0, InstrD<=NOP. Flush wins over StallD.
  - Else StallD: hold all D outputs.
  - Else: capture PCF, PCF+4, InstrF; ValidD<=1 unless shadow-squashed.
- Latency: PCF -> D outputs 1 cycle. BPU prediction -> target on PCF 1 cycle after PCBPUSrc.
- Simultaneous flushBranch and PCBPUSrc: flushBranch wins and the prediction is dropped.
- Reset asserted mid-stall: everything returns to reset values and the pending redirect is lost.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs PerfFetched, PerfSquashed, PerfRedirects, each 32-bit, reset 0, saturating at 32'hFFFF_FFFF.
  - PerfFetched: counts IF/ID captures with ValidD<=1.
  - PerfSquashed: counts captures or flushes that write ValidD<=0.
  - PerfRedirects: counts cycles where case 1 or 2 is taken.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR constant (32'h0000_0013).
  - RESET_PC default.
  - typedef struct packed ifid_t {pc, pc_plus4, instr, valid}.
  - typedef enum next_pc_sel_t {SEL_FLUSH, SEL_JUMP, SEL_PEND, SEL_PRED, SEL_HOLD, SEL_SEQ}.
- Sub-module if_id_reg: ifid_t register with stall/flush/async reset.

Test Plan:
- Reset release, no stalls, InstrF=32'h00A00093 -> PCF 0,4,8,...; ValidD=1 from cycle 2 with PCD=0.
- PCBPUSrc=1, PCBPU=32'h40 in the cycle PCF=8 -> next PCF=32'h40; instruction at PC 8 reaches D with ValidD=0, InstrD=NOP.
- PCBPUSrc=1, PCBPU=32'h80 during StallF for 3 cycles -> PCF holds; after StallF drops, PCF=32'h80 next cycle; pend_valid clears.
- flushBranch=1 and PCBPUSrc=1 together, PCBPU=32'h24 -> PCF=32'h24, ValidD=0, pend_valid=0.
- PCSrcE=1, PCTargetE=32'h100 with StallD=1 -> PCF=32'h100, ValidD=0 (flush beats stall).
- Reset asserted asynchronously mid-cycle with pend_valid=1 -> immediate PCF=RESET_PC, ValidD=0; perf counters (if FETCH_PERF_EN) read 0.
